// File: rtl/alu_seq.sv
// alu_seq: parametrised accumulator ALU (add/sub/logic/rotate/inc/dec), plus a
// multi-cycle shift-add multiplier and restoring divider behind start/busy/done.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             flags_we,
    input  logic [4:0]       flags_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [4:0]       flags
);
    localparam logic [3:0] OP_ADD  = 4'd0,  OP_ADC  = 4'd1,  OP_SUB = 4'd2,  OP_SBB = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4,  OP_XOR  = 4'd5,  OP_OR  = 4'd6,  OP_CMP = 4'd7;
    localparam logic [3:0] OP_RLC  = 4'd8,  OP_RRC  = 4'd9,  OP_RAL = 4'd10, OP_RAR = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12, OP_DIVU = 4'd13, OP_INR = 4'd14, OP_DCR = 4'd15;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIN} state_t;

    state_t             r_state, w_state_nx;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
    logic               r_cin;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy, r_done;
    logic [WIDTH-1:0]   r_result, r_result_hi;
    logic [4:0]         r_flags;

    logic               w_accept, w_long;
    logic [WIDTH:0]     w_madd, w_dshift, w_sum, w_dif;
    logic [WIDTH-1:0]   w_dsub, w_hi_nx, w_lo_nx;
    logic               w_dge;
    logic [WIDTH-1:0]   w_res, w_res_hi, w_fval;
    logic               w_c, w_v, w_z, w_keep_zsp;
    logic [4:0]         w_flags;

    // flags_we takes priority over start in the same cycle
    assign w_accept = (r_state == S_IDLE) && start && !flags_we;
    assign w_long   = (op == OP_MUL) || ((op == OP_DIVU) && (b_in != '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nx = w_long ? S_ITER : S_FIN;
            S_ITER:  if (r_cnt == CNT_W'(1)) w_state_nx = S_FIN;
            S_FIN:   w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // One iteration step. MUL: {r_hi,r_lo} is the product/multiplier pair shifted
    // right; DIVU: r_hi is the partial remainder, r_lo shifts dividend out / quotient in.
    assign w_madd   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    assign w_dshift = {r_hi, r_lo[WIDTH-1]};
    assign w_dge    = w_dshift >= {1'b0, r_b};
    assign w_dsub   = w_dshift[WIDTH-1:0] - r_b;

    always_comb begin
        if (r_op == OP_MUL) begin
            w_hi_nx = w_madd[WIDTH:1];
            w_lo_nx = {w_madd[0], r_lo[WIDTH-1:1]};
        end else begin
            w_hi_nx = w_dge ? w_dsub : w_dshift[WIDTH-1:0];
            w_lo_nx = {r_lo[WIDTH-2:0], w_dge};
        end
    end

    assign w_sum = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, (r_op == OP_ADC) & r_cin};
    assign w_dif = {1'b0, r_a} - {1'b0, r_b} - {{WIDTH{1'b0}}, (r_op == OP_SBB) & r_cin};

    always_comb begin
        w_res      = '0;
        w_res_hi   = '0;
        w_c        = r_flags[1];
        w_v        = 1'b0;
        w_keep_zsp = 1'b0;
        case (r_op)
            OP_ADD, OP_ADC: begin w_res = w_sum[WIDTH-1:0]; w_c = w_sum[WIDTH]; end
            OP_SUB, OP_SBB: begin w_res = w_dif[WIDTH-1:0]; w_c = w_dif[WIDTH]; end
            OP_AND:         begin w_res = r_a & r_b; w_c = 1'b0; end
            OP_XOR:         begin w_res = r_a ^ r_b; w_c = 1'b0; end
            OP_OR:          begin w_res = r_a | r_b; w_c = 1'b0; end
            OP_CMP:         begin w_res = r_a; w_c = w_dif[WIDTH]; end
            OP_RLC: begin
                w_res = {r_a[WIDTH-2:0], r_a[WIDTH-1]}; w_c = r_a[WIDTH-1]; w_keep_zsp = 1'b1;
            end
            OP_RRC: begin
                w_res = {r_a[0], r_a[WIDTH-1:1]}; w_c = r_a[0]; w_keep_zsp = 1'b1;
            end
            OP_RAL: begin
                w_res = {r_a[WIDTH-2:0], r_cin}; w_c = r_a[WIDTH-1]; w_keep_zsp = 1'b1;
            end
            OP_RAR: begin
                w_res = {r_cin, r_a[WIDTH-1:1]}; w_c = r_a[0]; w_keep_zsp = 1'b1;
            end
            OP_MUL:  begin w_res = r_lo; w_res_hi = r_hi; w_c = |r_hi; end
            OP_DIVU: begin
                w_c = 1'b0;
                if (r_b == '0) begin
                    w_res = '1; w_res_hi = r_a; w_v = 1'b1;
                end else begin
                    w_res = r_lo; w_res_hi = r_hi;
                end
            end
            OP_INR:  w_res = r_a + ONE;
            OP_DCR:  w_res = r_a - ONE;
            default: w_res = '0;
        endcase
    end

    // CMP reports flags of the difference while passing A through
    assign w_fval  = (r_op == OP_CMP) ? w_dif[WIDTH-1:0] : w_res;
    assign w_z     = (w_fval == '0) && !((r_op == OP_MUL) && (r_hi != '0));
    assign w_flags = w_keep_zsp ? {w_v, r_flags[3], r_flags[2], w_c, r_flags[0]}
                                : {w_v, w_fval[WIDTH-1], ~^w_fval, w_c, w_z};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_cin       <= 1'b0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_flags     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (flags_we) begin
                        r_flags <= flags_in;
                    end else if (start) begin
                        r_op   <= op;
                        r_a    <= a_in;
                        r_b    <= b_in;
                        r_cin  <= r_flags[1];
                        r_busy <= 1'b1;
                        r_cnt  <= CNT_W'(WIDTH);
                        r_hi   <= '0;
                        r_lo   <= (op == OP_MUL) ? b_in : a_in;
                    end
                end
                S_ITER: begin
                    r_hi  <= w_hi_nx;
                    r_lo  <= w_lo_nx;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                S_FIN: begin
                    r_result    <= w_res;
                    r_result_hi <= w_res_hi;
                    r_flags     <= w_flags;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign flags     = r_flags;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=8 and WIDTH=16: directed cases plus random ops
// checked against an arithmetic reference model.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        s8 = 1'b0, s16 = 1'b0, fwe8 = 1'b0, fwe16 = 1'b0;
    logic [3:0]  op = '0;
    logic [15:0] a = '0, b = '0;
    logic [4:0]  fin = '0;
    logic        busy8, done8, busy16, done16;
    logic [7:0]  res8, hi8;
    logic [15:0] res16, hi16;
    logic [4:0]  fl8, fl16;

    alu_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(s8), .op(op), .a_in(a[7:0]), .b_in(b[7:0]),
        .flags_we(fwe8), .flags_in(fin), .busy(busy8), .done(done8),
        .result(res8), .result_hi(hi8), .flags(fl8));

    alu_seq #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(s16), .op(op), .a_in(a), .b_in(b),
        .flags_we(fwe16), .flags_in(fin), .busy(busy16), .done(done16),
        .result(res16), .result_hi(hi16), .flags(fl16));

    int checks = 0;
    int failures = 0;
    logic [4:0]  ef8 = '0, ef16 = '0;
    logic [15:0] eres8 = '0;

    // Reference model straight from the op table, using wide integer arithmetic.
    function automatic void model(input int w, input int o, input longint av, input longint bv,
                                  input logic [4:0] fi, output longint er, output longint eh,
                                  output logic [4:0] fo, output int lat);
        longint m, t, fv, zsrc;
        bit c, v, keep, cin, z, s, par;
        m = (longint'(1) << w) - 1;
        cin = fi[1];
        er = 0; eh = 0; c = cin; v = 0; keep = 0; lat = 1; t = 0;
        case (o)
            0, 1:  begin t = av + bv + ((o == 1) ? longint'(cin) : 0); er = t & m; c = t > m; end
            2, 3:  begin t = av - bv - ((o == 3) ? longint'(cin) : 0); er = t & m; c = t < 0; end
            4:     begin er = av & bv; c = 0; end
            5:     begin er = av ^ bv; c = 0; end
            6:     begin er = av | bv; c = 0; end
            7:     begin t = av - bv; er = av; c = t < 0; end
            8:     begin c = ((av >> (w-1)) & 1) != 0; er = ((av << 1) | longint'(c)) & m; keep = 1; end
            9:     begin c = (av & 1) != 0; er = (av >> 1) | (longint'(c) << (w-1)); keep = 1; end
            10:    begin c = ((av >> (w-1)) & 1) != 0; er = ((av << 1) | longint'(cin)) & m; keep = 1; end
            11:    begin c = (av & 1) != 0; er = (av >> 1) | (longint'(cin) << (w-1)); keep = 1; end
            12:    begin t = av * bv; er = t & m; eh = t >> w; c = eh != 0; lat = w + 1; end
            13: begin
                c = 0;
                if (bv == 0) begin er = m; eh = av; v = 1; end
                else begin er = av / bv; eh = av % bv; lat = w + 1; end
            end
            14:    er = (av + 1) & m;
            default: er = (av - 1) & m;
        endcase
        fv = (o == 7) ? (t & m) : er;
        zsrc = (o == 12) ? t : fv;
        z = zsrc == 0;
        s = ((fv >> (w-1)) & 1) != 0;
        par = ($countones(fv) % 2) == 0;
        fo = keep ? {v, fi[3], fi[2], c, fi[0]} : {v, s, par, c, z};
    endfunction

    task automatic run_op(input bit wide, input logic [3:0] o, input logic [15:0] av,
                          input logic [15:0] bv, input bit poke);
        int w, lat, n;
        longint m, er, eh;
        logic [4:0] ef, rf;
        logic [15:0] ro, rh;
        bit got;
        w = wide ? 16 : 8;
        m = (longint'(1) << w) - 1;
        model(w, int'(o), longint'(av) & m, longint'(bv) & m, wide ? ef16 : ef8, er, eh, ef, lat);
        @(negedge clk);
        op = o; a = av; b = bv; s8 = !wide; s16 = wide;
        @(posedge clk); #1;
        s8 = 0; s16 = 0;
        checks++;
        if ((wide ? busy16 : busy8) !== 1'b1) begin
            failures++; $display("FAIL busy_after_start w=%0d op=%0d: got %b expected 1", w, o, wide ? busy16 : busy8);
        end
        n = 0; got = 0;
        while (!got && n < 3*w + 10) begin
            if (poke && n < 3) begin
                op = 4'($urandom); a = 16'($urandom); b = 16'($urandom); s8 = !wide; s16 = wide;
            end
            @(posedge clk); #1;
            s8 = 0; s16 = 0; n++;
            if ((wide ? done16 : done8) === 1'b1) got = 1;
        end
        ro = wide ? res16 : {8'h00, res8};
        rh = wide ? hi16 : {8'h00, hi8};
        rf = wide ? fl16 : fl8;
        checks++;
        if (!got || n != lat) begin
            failures++; $display("FAIL latency w=%0d op=%0d: got %0d (done seen %b) expected %0d", w, o, n, got, lat);
        end
        checks++;
        if (ro !== 16'(er) || rh !== 16'(eh) || rf !== ef) begin
            failures++;
            $display("FAIL result w=%0d op=%0d a=%h b=%h: got res=%h hi=%h fl=%b expected res=%h hi=%h fl=%b",
                     w, o, av, bv, ro, rh, rf, 16'(er), 16'(eh), ef);
        end
        checks++;
        if ((wide ? busy16 : busy8) !== 1'b0) begin
            failures++; $display("FAIL busy_with_done w=%0d op=%0d: got 1 expected 0", w, o);
        end
        if (wide) ef16 = ef;
        else begin ef8 = ef; eres8 = 16'(er); end
    endtask

    task automatic load_flags(input bit wide, input logic [4:0] v);
        @(negedge clk);
        fin = v; fwe8 = !wide; fwe16 = wide;
        @(posedge clk); #1;
        fwe8 = 0; fwe16 = 0;
        checks++;
        if ((wide ? fl16 : fl8) !== v) begin
            failures++; $display("FAIL flags_load: got %b expected %b", wide ? fl16 : fl8, v);
        end
        if (wide) ef16 = v; else ef8 = v;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({busy8, done8, res8, hi8, fl8, busy16, done16, res16, hi16, fl16} !== '0) begin
            failures++; $display("FAIL reset_state: got %h expected 0",
                                 {busy8, done8, res8, hi8, fl8, busy16, done16, res16, hi16, fl16});
        end
        @(negedge clk); rst = 1;
    endtask

    task automatic test_add_adc();
        run_op(0, 4'd0, 16'h00FF, 16'h0001, 0);
        checks++;
        if (res8 !== 8'h00 || fl8 !== 5'b00111) begin
            failures++; $display("FAIL add_ff_01: got res=%h fl=%b expected res=00 fl=00111", res8, fl8);
        end
        run_op(0, 4'd1, 16'h0010, 16'h0020, 0);
        checks++;
        if (res8 !== 8'h31) begin
            failures++; $display("FAIL adc_carry_in: got %h expected 31", res8);
        end
    endtask

    task automatic test_sub_cmp();
        run_op(0, 4'd2, 16'h0005, 16'h0007, 0);
        checks++;
        if (res8 !== 8'hFE || fl8[1] !== 1'b1 || fl8[3] !== 1'b1) begin
            failures++; $display("FAIL sub_borrow: got res=%h fl=%b expected res=fe C=1 S=1", res8, fl8);
        end
        run_op(0, 4'd7, 16'h0042, 16'h0042, 0);
        checks++;
        if (res8 !== 8'h42 || fl8[0] !== 1'b1 || fl8[1] !== 1'b0) begin
            failures++; $display("FAIL cmp_equal: got res=%h fl=%b expected res=42 Z=1 C=0", res8, fl8);
        end
    endtask

    task automatic test_mul_div();
        run_op(0, 4'd12, 16'h00FF, 16'h00FF, 1);
        checks++;
        if (res8 !== 8'h01 || hi8 !== 8'hFE || fl8[1] !== 1'b1) begin
            failures++; $display("FAIL mul_ff_ff: got lo=%h hi=%h C=%b expected lo=01 hi=fe C=1", res8, hi8, fl8[1]);
        end
        @(posedge clk); #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            failures++; $display("FAIL start_not_queued: got busy=%b done=%b expected 0 0", busy8, done8);
        end
        run_op(0, 4'd13, 16'd200, 16'd7, 0);
        checks++;
        if (res8 !== 8'd28 || hi8 !== 8'd4) begin
            failures++; $display("FAIL divu_200_7: got q=%0d r=%0d expected 28 4", res8, hi8);
        end
        run_op(0, 4'd13, 16'h0055, 16'h0000, 0);
        checks++;
        if (res8 !== 8'hFF || hi8 !== 8'h55 || fl8[4] !== 1'b1) begin
            failures++; $display("FAIL divu_by_zero: got q=%h r=%h V=%b expected ff 55 1", res8, hi8, fl8[4]);
        end
    endtask

    task automatic test_rotate_flags_we();
        load_flags(0, 5'b00001);
        run_op(0, 4'd10, 16'h0080, 16'h0000, 0);
        checks++;
        if (res8 !== 8'h00 || fl8 !== 5'b00011) begin
            failures++; $display("FAIL ral_80: got res=%h fl=%b expected res=00 fl=00011", res8, fl8);
        end
        @(negedge clk);
        fin = 5'h1F; fwe8 = 1; s8 = 1; op = 4'd0; a = 16'h0001; b = 16'h0001;
        @(posedge clk); #1;
        fwe8 = 0; s8 = 0;
        checks++;
        if (fl8 !== 5'h1F || busy8 !== 1'b0) begin
            failures++; $display("FAIL flags_we_wins: got fl=%b busy=%b expected 11111 0", fl8, busy8);
        end
        ef8 = 5'h1F;
        @(posedge clk); #1;
        checks++;
        if (done8 !== 1'b0 || {8'h00, res8} !== eres8) begin
            failures++; $display("FAIL start_dropped: got done=%b res=%h expected 0 %h", done8, res8, eres8[7:0]);
        end
    endtask

    task automatic test_abort();
        bit seen;
        @(negedge clk);
        op = 4'd12; a = 16'h0033; b = 16'h0044; s8 = 1;
        @(posedge clk); #1; s8 = 0;
        repeat (3) @(posedge clk);
        #2 rst = 0;
        #1;
        checks++;
        if ({busy8, done8, res8, hi8, fl8} !== '0) begin
            failures++; $display("FAIL abort_outputs: got %h expected 0", {busy8, done8, res8, hi8, fl8});
        end
        ef8 = '0; ef16 = '0; eres8 = '0;
        @(negedge clk); rst = 1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8 === 1'b1 || busy8 === 1'b1) seen = 1;
        end
        checks++;
        if (seen) begin
            failures++; $display("FAIL abort_no_done: got activity=1 expected 0");
        end
        run_op(0, 4'd0, 16'h0012, 16'h0034, 0);
    endtask

    task automatic test_back_to_back();
        run_op(0, 4'd14, 16'h00FF, 16'h0000, 0);
        run_op(0, 4'd15, 16'h0000, 16'h0000, 0);
        checks++;
        if (res8 !== 8'hFF || fl8[3] !== 1'b1) begin
            failures++; $display("FAIL dcr_wrap: got res=%h S=%b expected ff 1", res8, fl8[3]);
        end
        run_op(0, 4'd5, 16'h00A5, 16'h005A, 0);
    endtask

    task automatic test_wide();
        run_op(1, 4'd12, 16'hFFFF, 16'hFFFF, 1);
        checks++;
        if (res16 !== 16'h0001 || hi16 !== 16'hFFFE) begin
            failures++; $display("FAIL mul16: got lo=%h hi=%h expected 0001 fffe", res16, hi16);
        end
        run_op(1, 4'd13, 16'd50000, 16'd123, 0);
        run_op(1, 4'd13, 16'h1234, 16'h0000, 0);
        for (int i = 0; i < 25; i++) begin
            if (i % 7 == 3) load_flags(1, 5'($urandom));
            run_op(1, 4'($urandom), 16'($urandom), (i % 5 == 0) ? 16'h0 : 16'($urandom), 0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            if (i % 9 == 4) load_flags(0, 5'($urandom));
            run_op(0, 4'($urandom), 16'($urandom_range(0, 255)),
                   (i % 6 == 0) ? 16'h0 : 16'($urandom_range(0, 255)), 0);
        end
    endtask

    initial begin
        test_reset();
        test_add_adc();
        test_sub_cmp();
        test_mul_div();
        test_rotate_flags_we();
        test_abort();
        test_back_to_back();
        test_random();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised successor of the SAP3 8-bit accumulator ALU. Covers the same arithmetic, logic and rotate ops at any WIDTH.
- Adds a multi-cycle unsigned multiplier (shift-add) and divider (restoring).
- Uses a start/busy/done handshake so the control sequencer can stall on long ops.
- Sits between the register file/bus interface and the flags register in the datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (≥4).
- CNT_W, $clog2(WIDTH+1), iteration-counter width; derived, do not override.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  4  operation code, sampled with start
- a_in  in  WIDTH  operand A (accumulator), sampled with start
- b_in  in  WIDTH  operand B (temp), sampled with start
- flags_we  in  1  load flags from flags_in (ignored while busy)
- flags_in  in  5  flag load value
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse, result/result_hi/flags valid
- result  out  WIDTH  primary result / quotient / product low half
- result_hi  out  WIDTH  product high half / remainder; 0 for other ops
- flags  out  5  {V,S,P,C,Z} = bits [4:0] = {4:V,3:S,2:P,1:C,0:Z}

Behaviour:
- Reset (async, rst=0): state=IDLE; busy=0, done=0, result=0, result_hi=0, flags=0; counter and shift registers cleared. Asserting reset mid-operation aborts with no done pulse.
- FSM states:
  - IDLE: start=1 latches op/a_in/b_in and sets busy=1 next edge.
    - Single-cycle ops go to FIN.
    - MUL/DIVU go to ITER with counter=WIDTH; DIVU with b_in=0 goes to FIN directly.
  - ITER: one shift-add (MUL) or restoring-subtract step (DIVU) per cycle; counter decrements; at counter==1 go to FIN.
  - FIN: result/result_hi/flags registered, done=1, busy=0, back to IDLE.
- Latency (start sampled at edge k):
  - Single-cycle ops: done at edge k+1.
  - MUL/DIVU: done at edge k+WIDTH+1.
  - DIVU by zero: done at edge k+1.
- start in IDLE on the same edge done is high is accepted (back-to-back ops, one per 2 cycles minimum for single-cycle ops). start while busy: ignored, no queuing.
- flags_we in IDLE loads flags_in next edge. If start and flags_we coincide, flags_we wins for this edge and start is ignored.
- Ops (cin = flags.C latched at start):
  - 0 ADD, 1 ADC: result = A+B(+cin); C = carry-out.
  - 2 SUB, 3 SBB: result = A−B(−cin); C = borrow.
  - 4 AND, 5 XOR, 6 OR: C=0.
  - 7 CMP: flags from A−B as SUB; result=A unchanged.
  - 8 RLC, 9 RRC: rotate through the end bit; C = bit shifted out.
  - 10 RAL, 11 RAR: rotate through C.
  - 12 MUL: {result_hi,result} = A×B unsigned, 2·WIDTH bits; C = (result_hi≠0).
  - 13 DIVU: result = A/B, result_hi = A%B; C=0.
  - 14 INR, 15 DCR: A±1 mod 2^WIDTH; C unchanged.
- Flag rules:
  - Z, S, P are computed from result (MUL: Z from the full product).
  - P = 1 when even parity.
  - V = 1 only for DIVU with B=0; cleared by every other op.
  - Rotates update C only; Z/S/P unchanged.
- Divide by zero: result = all ones, result_hi = A, V=1, Z=0, S=result MSB, P from result.
- Between operations, outputs hold their last values. done is never high while busy is high.

Test Plan:
- WIDTH=8: ADD A=0xFF,B=0x01 → done at k+1, result=0x00, flags Z=1,C=1,P=1,S=0,V=0; then ADC A=0x10,B=0x20 → result=0x31.
- SUB A=0x05,B=0x07 → result=0xFE, C=1, S=1; CMP A=0x42,B=0x42 → result=0x42, Z=1, C=0.
- MUL A=0xFF,B=0xFF → busy=1 for 9 cycles, done at k+9, result=0x01, result_hi=0xFE, C=1; start pulses during busy are ignored.
- DIVU A=200,B=7 → done at k+9, result=28, result_hi=4; DIVU A=0x55,B=0 → done at k+1, result=0xFF, result_hi=0x55, V=1.
- RAL A=0x80 with C=0 → result=0x00, C=1, Z flag unchanged from prior op; flags_we with flags_in=0x1F and start together → flags=0x1F, no op executed.
- Assert rst at cycle 4 of a MUL → busy=0, done never pulses, all outputs 0; a new ADD afterwards completes normally. Repeat the MUL and DIVU cases at WIDTH=16 (latency 17).
